mem_arb_clear: RTL and testbench

Shared-memory controller in front of the SoC's single-port 1024×32 word RAM. It arbitrates between two Ibex-style requesters (port 0 = instruction fetch, port 1 = data/load-store) using round-robin priority. It also owns a hardware zero-fill sequencer that clears every word after reset and on demand, so simulation and silicon start from the same all-zero contents. It sits between the core's memory ports and the RAM macro inside the SoC.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_arb_clear_if.sv | 24 ++
 rtl/rr_arb2.sv | 12 +
 rtl/mem_arb_clear.sv | 116 +++++++++++
 tb/tb_mem_arb_clear.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter with zero-fill sequencer.
package mem_arb_pkg;

    localparam int unsigned DEPTH_DEFAULT = 1024;
    localparam int unsigned NPORTS        = 2;
    localparam int unsigned PORT_INSTR    = 0;
    localparam int unsigned PORT_DATA     = 1;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_e;

    // One requester's access as presented to the RAM
    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_arb_clear_if.sv
// Requester-side bus of mem_arb_clear: two Ibex-style request/grant/response ports.
interface mem_arb_clear_if;
    import mem_arb_pkg::*;

    logic [NPORTS-1:0]        req_i;
    logic [NPORTS-1:0]        we_i;
    logic [NPORTS-1:0][3:0]   be_i;
    logic [NPORTS-1:0][31:0]  addr_i;
    logic [NPORTS-1:0][31:0]  wdata_i;
    logic [NPORTS-1:0]        gnt_o;
    logic [NPORTS-1:0]        rvalid_o;
    logic [31:0]              rdata_o;

    modport master (
        output req_i, we_i, be_i, addr_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o
    );

    modport slave (
        input  req_i, we_i, be_i, addr_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; last_i names the port that won most recently.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);

    assign gnt_o[0] = en_i & req_i[0] & (~req_i[1] | last_i);
    assign gnt_o[1] = en_i & req_i[1] & (~req_i[0] | ~last_i);

endmodule

// File: rtl/mem_arb_clear.sv
// Single-port RAM controller: round-robin between fetch and data ports, plus a
// zero-fill sequencer that clears every word after reset and on clear_i.
module mem_arb_clear
    import mem_arb_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              resetn,
    mem_arb_clear_if.slave    bus,
    input  logic              clear_i,
    output logic              busy_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [AW-1:0]     mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
);

    localparam logic [0:0] S_CLEAR = 1'(CLEAR);
    localparam logic [0:0] S_IDLE  = 1'(IDLE);

    logic [0:0]    state_q, state_d;
    logic [AW-1:0] clr_addr_q, clr_addr_d;
    logic          last_q, last_d;
    logic          run_q;
    logic [1:0]    rvalid_q;
    logic          arb_en;
    logic [1:0]    gnt;
    logic          win_idx;
    mem_req_t      win;
    logic          unused_addr_bits;

    assign arb_en = (state_q == S_IDLE) && !clear_i;

    rr_arb2 u_arb (
        .req_i  (bus.req_i),
        .last_i (last_q),
        .en_i   (arb_en),
        .gnt_o  (gnt)
    );

    assign win_idx   = gnt[PORT_DATA];
    assign win.we    = bus.we_i[win_idx];
    assign win.be    = bus.be_i[win_idx];
    assign win.addr  = bus.addr_i[win_idx];
    assign win.wdata = bus.wdata_i[win_idx];

    // Only the word-address bits reach the RAM
    assign unused_addr_bits = ^{win.addr[31:AW+2], win.addr[1:0]};

    // Next state and RAM drive
    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        last_d      = last_q;
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_addr_o  = '0;
        mem_wdata_o = 32'h0;
        case (state_q)
            S_CLEAR: begin
                // run_q holds off the first write until one edge after reset release
                if (run_q) begin
                    mem_en_o   = 1'b1;
                    mem_we_o   = 1'b1;
                    mem_be_o   = 4'hF;
                    mem_addr_o = clr_addr_q;
                    if (clr_addr_q == AW'(DEPTH - 1)) begin
                        clr_addr_d = '0;
                        state_d    = S_IDLE;
                    end else begin
                        clr_addr_d = clr_addr_q + AW'(1);
                    end
                end
            end
            default: begin
                if (clear_i) begin
                    state_d = S_CLEAR;
                end else if (|gnt) begin
                    mem_en_o    = 1'b1;
                    mem_we_o    = win.we;
                    mem_be_o    = win.be;
                    mem_addr_o  = win.addr[AW+1:2];
                    mem_wdata_o = win.wdata;
                    last_d      = win_idx;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_CLEAR;
            clr_addr_q <= '0;
            last_q     <= 1'b1;
            run_q      <= 1'b0;
            rvalid_q   <= 2'b00;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            last_q     <= last_d;
            run_q      <= 1'b1;
            rvalid_q   <= gnt;
        end
    end

    assign busy_o       = (state_q == S_CLEAR);
    assign bus.gnt_o    = gnt;
    assign bus.rvalid_o = rvalid_q;
    assign bus.rdata_o  = mem_rdata_i;

endmodule

// File: tb/tb_mem_arb_clear.sv
// Bench for mem_arb_clear: RAM macro model, behavioural reference, directed and random traffic.
module tb_mem_arb_clear;
    import mem_arb_pkg::*;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned AW    = 10;

    logic          clk     = 1'b0;
    logic          resetn  = 1'b0;
    logic          clear_i = 1'b0;
    logic          busy_o;
    logic          mem_en_o;
    logic          mem_we_o;
    logic [3:0]    mem_be_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic [31:0]   mem_rdata_i;

    mem_arb_clear_if bus ();

    mem_arb_clear #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .bus         (bus.slave),
        .clear_i     (clear_i),
        .busy_o      (busy_o),
        .mem_en_o    (mem_en_o),
        .mem_we_o    (mem_we_o),
        .mem_be_o    (mem_be_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // RAM macro: one-cycle read latency, byte-masked writes, preloaded with junk
    logic [31:0] ram [DEPTH];
    always @(posedge clk) begin
        if (mem_en_o) begin
            if (mem_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be_o[b]) ram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
            end else begin
                mem_rdata_i <= ram[mem_addr_o];
            end
        end
    end

    // Reference model
    bit          m_busy    = 1'b1;
    bit          m_started = 1'b0;
    int          m_pos     = 0;
    int          m_prio    = 0;
    logic [1:0]  m_rv      = 2'b00;
    bit          m_rd      = 1'b0;
    logic [31:0] m_rdata   = 32'h0;
    logic [31:0] m_mem [DEPTH];

    initial begin
        mem_rdata_i = 32'h0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            ram[i]   = 32'hDEADBEEF;
            m_mem[i] = 32'hDEADBEEF;
        end
    end

    function automatic int pick(input logic [1:0] r, input int prio);
        if (r == 2'b11) return prio;
        if (r[0]) return 0;
        if (r[1]) return 1;
        return -1;
    endfunction

    always @(posedge clk) begin : model_update
        int w;
        int wd;
        if (!resetn) begin
            m_busy = 1'b1; m_started = 1'b0; m_pos = 0; m_prio = 0; m_rv = 2'b00; m_rd = 1'b0;
        end else if (m_busy) begin
            m_rv = 2'b00;
            m_rd = 1'b0;
            if (m_started) begin
                m_mem[m_pos] = 32'h0;
                if (m_pos == int'(DEPTH) - 1) begin
                    m_pos  = 0;
                    m_busy = 1'b0;
                end else begin
                    m_pos++;
                end
            end
            m_started = 1'b1;
        end else if (clear_i) begin
            m_busy = 1'b1; m_rv = 2'b00; m_rd = 1'b0;
        end else begin
            w = pick(bus.req_i, m_prio);
            if (w < 0) begin
                m_rv = 2'b00;
                m_rd = 1'b0;
            end else begin
                m_rv = (w == 0) ? 2'b01 : 2'b10;
                wd   = int'(bus.addr_i[w][11:2]);
                m_rd = !bus.we_i[w];
                if (bus.we_i[w]) begin
                    for (int b = 0; b < 4; b++)
                        if (bus.be_i[w][b]) m_mem[wd][8*b +: 8] = bus.wdata_i[w][8*b +: 8];
                end else begin
                    m_rdata = m_mem[wd];
                end
                m_prio = 1 - w;
            end
        end
    end

    always @(negedge clk) begin : compare
        int w;
        logic [1:0] eg;
        if (!resetn) begin
            check("rst_busy",   32'(busy_o),       32'd1);
            check("rst_gnt",    32'(bus.gnt_o),    32'd0);
            check("rst_mem_en", 32'(mem_en_o),     32'd0);
            check("rst_rvalid", 32'(bus.rvalid_o), 32'd0);
        end else begin
            check("busy",   32'(busy_o),       32'(m_busy));
            check("rvalid", 32'(bus.rvalid_o), 32'(m_rv));
            if (m_rd && m_rv != 2'b00) check("rdata", bus.rdata_o, m_rdata);
            if (m_busy) begin
                check("clr_gnt",    32'(bus.gnt_o), 32'd0);
                check("clr_mem_en", 32'(mem_en_o),  32'(m_started));
                if (m_started) begin
                    check("clr_addr",  32'(mem_addr_o), 32'(m_pos));
                    check("clr_we",    32'(mem_we_o),   32'd1);
                    check("clr_be",    32'(mem_be_o),   32'hF);
                    check("clr_wdata", mem_wdata_o,     32'h0);
                end
            end else begin
                w  = clear_i ? -1 : pick(bus.req_i, m_prio);
                eg = (w < 0) ? 2'b00 : ((w == 0) ? 2'b01 : 2'b10);
                check("gnt",    32'(bus.gnt_o), 32'(eg));
                check("mem_en", 32'(mem_en_o),  32'(w >= 0));
                if (w >= 0) begin
                    check("mem_we",   32'(mem_we_o),   32'(bus.we_i[w]));
                    check("mem_be",   32'(mem_be_o),   32'(bus.be_i[w]));
                    check("mem_addr", 32'(mem_addr_o), 32'(bus.addr_i[w][11:2]));
                    if (bus.we_i[w]) check("mem_wdata", mem_wdata_o, bus.wdata_i[w]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input bit r, input bit we, input logic [3:0] be,
                            input logic [31:0] a, input logic [31:0] d);
        bus.req_i[p]   = r;
        bus.we_i[p]    = we;
        bus.be_i[p]    = be;
        bus.addr_i[p]  = a;
        bus.wdata_i[p] = d;
    endtask

    function automatic int count_nonzero();
        int c = 0;
        for (int i = 0; i < int'(DEPTH); i++) if (ram[i] != 32'h0) c++;
        return c;
    endfunction

    // Caller releases reset just after an edge; the next edge is the first clear edge
    task automatic measure_clear(input string tag);
        int cnt = 0;
        logic [AW-1:0] first = '1;
        @(posedge clk);
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (!busy_o) break;
            if (cnt == 0) first = mem_addr_o;
            cnt++;
        end
        check({tag, "_busy_cycles"}, 32'(cnt),   32'd1024);
        check({tag, "_first_addr"},  32'(first), 32'd0);
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (!busy_o) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_idle_reached"}, 32'(ok), 32'd1);
    endtask

    initial begin : watchdog
        #1000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : stimulus
        logic [11:0] gseq;
        logic [11:0] rseq;
        bit          pend [2];
        logic [1:0]  gseen;
        int          hold;
        int          diff;

        set_port(PORT_INSTR, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        set_port(PORT_DATA,  1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        resetn = 1'b0;
        repeat (3) step();
        resetn = 1'b1;
        measure_clear("reset");
        check("reset_zero_words", 32'(count_nonzero()), 32'd0);

        // Single port write then read
        step(); set_port(1, 1'b1, 1'b1, 4'hF, 32'h10, 32'h12345678);
        @(negedge clk);
        check("single_wr_gnt",  32'(bus.gnt_o),  32'd2);
        check("single_wr_addr", 32'(mem_addr_o), 32'd4);
        step(); set_port(1, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
        @(negedge clk);
        check("single_wr_rvalid", 32'(bus.rvalid_o), 32'd2);
        check("single_rd_gnt",    32'(bus.gnt_o),    32'd2);
        step(); set_port(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        check("single_rd_rvalid", 32'(bus.rvalid_o), 32'd2);
        check("single_rd_data",   bus.rdata_o,       32'h12345678);

        // Contention for six cycles
        step();
        set_port(0, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
        set_port(1, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
        gseq = '0;
        rseq = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            gseq = {gseq[9:0], bus.gnt_o};
            if (i > 0) rseq = {rseq[9:0], bus.rvalid_o};
            if (i < 5) step();
        end
        step();
        set_port(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        set_port(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        rseq = {rseq[9:0], bus.rvalid_o};
        check("contention_gnt_seq",    32'(gseq), 32'h666);
        check("contention_rvalid_seq", 32'(rseq), 32'h666);

        // Byte-masked write
        step(); set_port(0, 1'b1, 1'b1, 4'b0101, 32'h0, 32'hAABBCCDD);
        @(negedge clk);
        check("be_wr_gnt", 32'(bus.gnt_o), 32'd1);
        step(); set_port(0, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
        @(negedge clk);
        step(); set_port(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        check("be_rd_rvalid", 32'(bus.rvalid_o), 32'd1);
        check("be_rd_data",   bus.rdata_o,       32'h00BB00DD);

        // Clear colliding with a request
        step(); set_port(0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
        @(negedge clk);
        check("coll_pre_gnt", 32'(bus.gnt_o), 32'd1);
        step(); clear_i = 1'b1;
        @(negedge clk);
        check("coll_gnt",    32'(bus.gnt_o),    32'd0);
        check("coll_rvalid", 32'(bus.rvalid_o), 32'd1);
        check("coll_rdata",  bus.rdata_o,       32'h12345678);
        step(); clear_i = 1'b0; set_port(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        check("coll_busy", 32'(busy_o), 32'd1);
        wait_idle("coll");
        check("coll_zero_words", 32'(count_nonzero()), 32'd0);

        // Reset in the middle of a clear
        step(); clear_i = 1'b1;
        step(); clear_i = 1'b0;
        repeat (499) step();
        resetn = 1'b0;
        repeat (3) step();
        resetn = 1'b1;
        measure_clear("reset_mid");

        // Random traffic with occasional clears
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        gseen   = 2'b00;
        hold    = 0;
        for (int c = 0; c < 3000; c++) begin
            step();
            for (int p = 0; p < 2; p++) begin
                if (pend[p] && gseen[p]) pend[p] = 1'b0;
                if (!pend[p] && $urandom_range(0, 2) != 0) begin
                    pend[p] = 1'b1;
                    set_port(p, 1'b1, 1'($urandom_range(0, 1)), 4'($urandom),
                             {20'($urandom), 10'($urandom_range(0, 15)), 2'($urandom)}, $urandom);
                end
                if (!pend[p]) bus.req_i[p] = 1'b0;
            end
            if (hold > 0) begin
                clear_i = 1'b1;
                hold--;
            end else if ($urandom_range(0, 499) == 0) begin
                clear_i = 1'b1;
                hold    = $urandom_range(0, 2);
            end else begin
                clear_i = 1'b0;
            end
            @(negedge clk);
            gseen = bus.gnt_o;
        end
        step();
        clear_i = 1'b0;
        set_port(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        set_port(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        wait_idle("final");
        step();
        step();
        diff = 0;
        for (int i = 0; i < int'(DEPTH); i++) if (ram[i] !== m_mem[i]) diff++;
        check("ram_vs_model", 32'(diff), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
